// File: rtl/dest_header_tx.sv
// dest_header_tx
// Transmit side of the node destination check. On start it captures this node's
// ID, a destination ID and a payload length, then streams a 4-word header over a
// valid/ready interface: DEST, SRC, LEN, CHECKSUM (DEST ^ SRC ^ LEN).
//
// Ports
//   clock, nrst          clock and asynchronous active-low reset
//   en                   global enable; low freezes all state and drops out_valid
//   start                header request, sampled only in IDLE
//   MY_NODE_ID           this node's ID (SRC word)
//   destinationID        target node ID (DEST word)
//   payload_len          payload length, zero-extended into the LEN word
//   out_ready            downstream ready
//   out_valid/out_data   header word stream
//   out_last             marks the CHECKSUM word
//   busy                 high in SEND and DONE
//   self_addr            captured DEST == captured SRC, valid while busy
//   done                 one-cycle pulse after the last word is accepted
//
// state | meaning
// IDLE  | waiting for start
// SEND  | emitting header word idx
// DONE  | done asserted; returns to IDLE on the next enabled edge

module dest_header_tx #(
    parameter int ID_W  = 16,
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             nrst,
    input  logic             en,
    input  logic             start,
    input  logic [ID_W-1:0]  MY_NODE_ID,
    input  logic [ID_W-1:0]  destinationID,
    input  logic [LEN_W-1:0] payload_len,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ID_W-1:0]  out_data,
    output logic             out_last,
    output logic             busy,
    output logic             self_addr,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      idx_q;
    logic [ID_W-1:0] dest_q;
    logic [ID_W-1:0] src_q;
    logic [ID_W-1:0] len_q;
    logic            self_q;
    logic [ID_W-1:0] chk_w;

    assign chk_w = dest_q ^ src_q ^ len_q;

    // out_valid is the only output that depends combinationally on an input (en),
    // so a disabled cycle never presents a word downstream.
    assign out_valid = en & (state_q == ST_SEND);
    assign out_last  = (state_q == ST_SEND) && (idx_q == 2'd3);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign self_addr = self_q;

    // Word select depends only on registered idx/captures, so data holds
    // under backpressure and while en is low.
    always_comb begin
        out_data = '0;
        if (state_q == ST_SEND) begin
            case (idx_q)
                2'd0:    out_data = dest_q;
                2'd1:    out_data = src_q;
                2'd2:    out_data = len_q;
                default: out_data = chk_w;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            dest_q  <= '0;
            src_q   <= '0;
            len_q   <= '0;
            self_q  <= 1'b0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dest_q  <= destinationID;
                        src_q   <= MY_NODE_ID;
                        len_q   <= ID_W'(payload_len);
                        self_q  <= (destinationID == MY_NODE_ID);
                        idx_q   <= 2'd0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // en is already high here, so out_ready alone marks a transfer.
                    if (out_ready) begin
                        if (idx_q == 2'd3) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    self_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
